// File: rtl/hex_display_ctrl_if.sv
// Bus bundle for hex_display_ctrl: captured value, raw push-buttons, blanking
// control and the registered segment/page/freeze outputs.
interface hex_display_ctrl_if #(
   parameter int DATA_W = 64,
   parameter int DIGITS = 8
);
   localparam int NPAGES = (DATA_W + 4*DIGITS - 1) / (4*DIGITS);
   localparam int PW     = (NPAGES > 1) ? $clog2(NPAGES) : 1;

   logic [DATA_W-1:0]   value;
   logic                value_vld;
   logic                key_page_n;
   logic                key_frz_n;
   logic                blank_lz;
   logic [DIGITS*7-1:0] seg;
   logic [PW-1:0]       page;
   logic                frozen;

   modport master (
      output value, value_vld, key_page_n, key_frz_n, blank_lz,
      input  seg, page, frozen
   );

   modport slave (
      input  value, value_vld, key_page_n, key_frz_n, blank_lz,
      output seg, page, frozen
   );
endinterface

// File: rtl/hex_display_ctrl.sv
// Seven-segment hex display controller: shadow capture with freeze, debounced
// paging across DIGITS digits, and leading-zero blanking over the whole value.
module hex_display_ctrl #(
   parameter int DATA_W         = 64,
   parameter int DIGITS         = 8,
   parameter int DEBOUNCE_CYC   = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   hex_display_ctrl_if.slave  bus
);
   localparam int NPAGES = (DATA_W + 4*DIGITS - 1) / (4*DIGITS);
   localparam int PW     = (NPAGES > 1) ? $clog2(NPAGES) : 1;
   localparam int NVAL   = (DATA_W + 3) / 4;
   localparam int EXTW   = 4 * NPAGES * DIGITS;
   localparam int CW     = $clog2(DEBOUNCE_CYC);
   localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

   function automatic logic [6:0] hex_encode(input logic [3:0] nib);
      case (nib)
         4'h0:    hex_encode = 7'b1000000;
         4'h1:    hex_encode = 7'b1111001;
         4'h2:    hex_encode = 7'b0100100;
         4'h3:    hex_encode = 7'b0110000;
         4'h4:    hex_encode = 7'b0011001;
         4'h5:    hex_encode = 7'b0010010;
         4'h6:    hex_encode = 7'b0000010;
         4'h7:    hex_encode = 7'b1111000;
         4'h8:    hex_encode = 7'b0000000;
         4'h9:    hex_encode = 7'b0010000;
         4'hA:    hex_encode = 7'b0001000;
         4'hB:    hex_encode = 7'b0000011;
         4'hC:    hex_encode = 7'b0100111;
         4'hD:    hex_encode = 7'b0100001;
         4'hE:    hex_encode = 7'b0000110;
         4'hF:    hex_encode = 7'b0001110;
         default: hex_encode = 7'b1111111;
      endcase
   endfunction

   // Key index 0 is the page button, index 1 the freeze button.
   logic [1:0]          key_raw_s;
   logic [1:0]          sync1_q, sync2_q, stable_q, stable_d, press_s;
   logic [CW-1:0]       cnt_q [2];
   logic [CW-1:0]       cnt_d [2];
   logic [PW-1:0]       page_q, page_d;
   logic                frozen_q, frozen_d;
   logic [DATA_W-1:0]   shadow_q, shadow_d;
   logic [DIGITS*7-1:0] seg_q, seg_d;
   logic [EXTW-1:0]     ext_s;
   logic [NVAL-1:0]     lz_s;
   logic                zero_above_s;

   assign key_raw_s = {bus.key_frz_n, bus.key_page_n};
   assign ext_s     = EXTW'(shadow_q);

   // Debounce: flip the stable level after DEBOUNCE_CYC mismatching cycles
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         stable_d[k] = stable_q[k];
         cnt_d[k]    = '0;
         press_s[k]  = 1'b0;
         if (sync2_q[k] != stable_q[k]) begin
            if (cnt_q[k] == CW'(DEBOUNCE_CYC - 1)) begin
               stable_d[k] = sync2_q[k];
               press_s[k]  = stable_q[k];
            end else begin
               cnt_d[k] = cnt_q[k] + CW'(1);
            end
         end else begin
            cnt_d[k] = '0;
         end
      end
   end

   // Page, freeze and capture next state; capture sees the pre-toggle freeze
   always_comb begin
      page_d   = page_q;
      frozen_d = frozen_q ^ press_s[1];
      shadow_d = shadow_q;
      if (press_s[0]) begin
         page_d = (page_q == PW'(NPAGES - 1)) ? '0 : page_q + PW'(1);
      end else begin
         page_d = page_q;
      end
      if (bus.value_vld && !frozen_q) begin
         shadow_d = bus.value;
      end else begin
         shadow_d = shadow_q;
      end
   end

   // Leading-zero mask over all valid nibbles, scanning from the top
   always_comb begin
      zero_above_s = 1'b1;
      lz_s         = '0;
      for (int n = NVAL - 1; n >= 0; n--) begin
         zero_above_s = zero_above_s && (ext_s[4*n +: 4] == 4'h0);
         lz_s[n]      = bus.blank_lz && zero_above_s && (n != 0);
      end
   end

   // Segment decode of the selected page; nibbles past DATA_W show blank
   always_comb begin
      seg_d = '0;
      for (int d = 0; d < DIGITS; d++) begin
         int         idx;
         logic [6:0] code;
         idx  = int'(page_q) * DIGITS + d;
         code = 7'h7F;
         if (idx < NVAL) begin
            if (!lz_s[idx]) begin
               code = hex_encode(ext_s[4*idx +: 4]);
            end else begin
               code = 7'h7F;
            end
         end else begin
            code = 7'h7F;
         end
         seg_d[7*d +: 7] = SEG_ACTIVE_LOW ? code : ~code;
      end
   end

   // State registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q  <= 2'b11;
         sync2_q  <= 2'b11;
         stable_q <= 2'b11;
         cnt_q    <= '{default: '0};
         page_q   <= '0;
         frozen_q <= 1'b0;
         shadow_q <= '0;
         seg_q    <= {DIGITS{SEG_OFF}};
      end else begin
         sync1_q  <= key_raw_s;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         page_q   <= page_d;
         frozen_q <= frozen_d;
         shadow_q <= shadow_d;
         seg_q    <= seg_d;
      end
   end

   assign bus.seg    = seg_q;
   assign bus.page   = page_q;
   assign bus.frozen = frozen_q;
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl (DATA_W=64, DIGITS=8, DEBOUNCE_CYC=4).
module tb_hex_display_ctrl;
   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011;
   localparam logic [6:0] SC = 7'b0100111, SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110;
   localparam logic [6:0] BL = 7'b1111111;

   typedef struct {
      logic [63:0] value;
      logic        blz;
      logic [55:0] exp_p0;
      logic [55:0] exp_p1;
   } vec_t;

   typedef struct {
      string       name;
      logic [55:0] seg;
      logic        page;
      logic        frozen;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   int     n_vec = 0;
   int     n_err = 0;
   exp_t   sbq[$];
   vec_t   vecs[6];

   hex_display_ctrl_if #(.DATA_W(64), .DIGITS(8)) bus ();

   hex_display_ctrl #(
      .DATA_W(64), .DIGITS(8), .DEBOUNCE_CYC(4), .SEG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic sb_push(input string nm, input logic [55:0] s, input logic p, input logic f);
      exp_t e;
      e.name = nm; e.seg = s; e.page = p; e.frozen = f;
      sbq.push_back(e);
   endtask

   task automatic sb_check();
      exp_t e;
      if (sbq.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL sb_empty: got 0 entries expected 1");
      end else begin
         e = sbq.pop_front();
         cmp({e.name, "_seg"}, 64'(bus.seg), 64'(e.seg));
         cmp({e.name, "_page"}, 64'(bus.page), 64'(e.page));
         cmp({e.name, "_frozen"}, 64'(bus.frozen), 64'(e.frozen));
      end
   endtask

   task automatic capture(input logic [63:0] v);
      bus.value     = v;
      bus.value_vld = 1'b1;
      tick(1);
      bus.value_vld = 1'b0;
      tick(1);
   endtask

   task automatic press_page();
      bus.key_page_n = 1'b0;
      tick(10);
      bus.key_page_n = 1'b1;
      tick(8);
   endtask

   task automatic press_frz();
      bus.key_frz_n = 1'b0;
      tick(10);
      bus.key_frz_n = 1'b1;
      tick(8);
   endtask

   initial begin
      int n;
      vecs[0] = '{64'h0123_4567_89AB_CDEF, 1'b0,
                  {S8, S9, SA, SB, SC, SD, SE, SF}, {S0, S1, S2, S3, S4, S5, S6, S7}};
      vecs[1] = '{64'h0000_0000_0000_00A5, 1'b1, {{6{BL}}, SA, S5}, {8{BL}}};
      vecs[2] = '{64'h0000_0000_0000_0000, 1'b1, {{7{BL}}, S0}, {8{BL}}};
      vecs[3] = '{64'h0000_0000_0000_0000, 1'b0, {8{S0}}, {8{S0}}};
      vecs[4] = '{64'h0000_0001_0000_0000, 1'b1, {8{S0}}, {{7{BL}}, S1}};
      vecs[5] = '{64'hFEDC_BA98_7654_3210, 1'b1,
                  {S7, S6, S5, S4, S3, S2, S1, S0}, {SF, SE, SD, SC, SB, SA, S9, S8}};

      bus.value = '0; bus.value_vld = 1'b0; bus.blank_lz = 1'b0;
      bus.key_page_n = 1'b1; bus.key_frz_n = 1'b1;
      tick(3);
      sb_push("reset", {8{BL}}, 1'b0, 1'b0);
      sb_check();
      rst = 1'b0;
      tick(2);

      // Capture, page forward, wrap back
      for (int i = 0; i < 6; i++) begin
         bus.blank_lz = vecs[i].blz;
         sb_push($sformatf("v%0d_p0", i), vecs[i].exp_p0, 1'b0, 1'b0);
         capture(vecs[i].value);
         sb_check();
         sb_push($sformatf("v%0d_p1", i), vecs[i].exp_p1, 1'b1, 1'b0);
         press_page();
         sb_check();
         sb_push($sformatf("v%0d_wrap", i), vecs[i].exp_p0, 1'b0, 1'b0);
         press_page();
         sb_check();
      end

      // Freeze blocks capture, unfreeze re-enables it
      sb_push("frz_on", vecs[5].exp_p0, 1'b0, 1'b1);
      press_frz();
      sb_check();
      sb_push("frz_hold", vecs[5].exp_p0, 1'b0, 1'b1);
      capture(64'hFFFF_FFFF_FFFF_FFFF);
      sb_check();
      sb_push("frz_off", vecs[5].exp_p0, 1'b0, 1'b0);
      press_frz();
      sb_check();
      sb_push("frz_cap", {8{SF}}, 1'b0, 1'b0);
      capture(64'hFFFF_FFFF_FFFF_FFFF);
      sb_check();

      // Capture coincident with the freeze press edge
      bus.key_frz_n = 1'b0;
      tick(5);
      sb_push("vld_frz", vecs[0].exp_p0, 1'b0, 1'b1);
      capture(64'h0123_4567_89AB_CDEF);
      sb_check();
      bus.key_frz_n = 1'b1;
      tick(8);

      // Page and freeze pressed together
      bus.key_page_n = 1'b0; bus.key_frz_n = 1'b0;
      tick(10);
      bus.key_page_n = 1'b1; bus.key_frz_n = 1'b1;
      tick(8);
      sb_push("pg_frz", {BL, S1, S2, S3, S4, S5, S6, S7}, 1'b1, 1'b0);
      sb_check();
      sb_push("pg_back", vecs[0].exp_p0, 1'b0, 1'b0);
      press_page();
      sb_check();

      // Bounce shorter than the debounce window is ignored
      bus.key_page_n = 1'b0; tick(3);
      bus.key_page_n = 1'b1; tick(1);
      bus.key_page_n = 1'b0; tick(3);
      bus.key_page_n = 1'b1; tick(10);
      sb_push("bounce", vecs[0].exp_p0, 1'b0, 1'b0);
      sb_check();
      bus.key_page_n = 1'b0; tick(100);
      bus.key_page_n = 1'b1; tick(8);
      sb_push("hold_one", {BL, S1, S2, S3, S4, S5, S6, S7}, 1'b1, 1'b0);
      sb_check();

      // Reset while a key is held, then one event after release
      bus.blank_lz = 1'b0;
      bus.key_page_n = 1'b0;
      tick(3);
      rst = 1'b1;
      tick(2);
      sb_push("rst_mid", {8{BL}}, 1'b0, 1'b0);
      sb_check();
      rst = 1'b0;
      n = 0;
      while (bus.page !== 1'b1 && n < 30) begin
         tick(1);
         n++;
      end
      cmp("rst_evt_lat", 64'(n), 64'd6);
      tick(1);
      sb_push("post_rst", {8{S0}}, 1'b1, 1'b0);
      sb_check();
      tick(20);
      sb_push("held_no_repeat", {8{S0}}, 1'b1, 1'b0);
      sb_check();
      bus.key_page_n = 1'b1;
      tick(8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
Parametrised seven-segment display controller for board-level bring-up of datapath blocks (ALU, register file, PC).
- Captures a DATA_W-bit value into a shadow register on a valid strobe, unless frozen.
- Pages the value across DIGITS hex digits using a debounced push-button.
- Supports a freeze toggle and leading-zero blanking.
- Supersedes per-design hand-written hex decode blocks.

Parameters:
DATA_W, 64, width of displayed value (must be >= 4)
DIGITS, 8, number of seven-segment digits
DEBOUNCE_CYC, 50000, consecutive stable cycles for a key to register (>= 2)
SEG_ACTIVE_LOW, 1, 1 = segment lit on 0; 0 = segment lit on 1

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
value  in  DATA_W  value to display
value_vld  in  1  capture strobe for value
key_page_n  in  1  raw page button, active-low, asynchronous
key_frz_n  in  1  raw freeze button, active-low, asynchronous
blank_lz  in  1  enable leading-zero blanking (level, sampled every cycle)
seg  out  DIGITS*7  segments; digit d at [7d+6:7d], bit 0 = segment a
page  out  PW  current page, PW = max(1, clog2(NPAGES))
frozen  out  1  freeze state

Behaviour:
- NPAGES = ceil(DATA_W / (4*DIGITS)). Page p shows nibbles [p*DIGITS +: DIGITS]; digit 0 is the least significant nibble of the page.
- Reset values (async on RST rise, held while RST=1):
  - shadow = 0, page = 0, frozen = 0
  - debounce stable states = 1 (released), debounce counters = 0, sync flops = 1
  - seg = all segments off (7'h7F per digit when SEG_ACTIVE_LOW=1)
- Key path: 2-flop synchroniser, then debounce.
  - Counter increments while synced level != stable level; it clears on match.
  - When the counter reaches DEBOUNCE_CYC-1 with mismatch still present, the stable level flips and the counter clears.
  - A press event is a one-cycle pulse on a stable 1->0 transition. Release generates no event. Holding a key produces exactly one event.
- Page: on page press event, page <= (page == NPAGES-1) ? 0 : page+1. When NPAGES = 1, page stays 0.
- Freeze: on freeze press event, frozen <= ~frozen.
- Capture: shadow <= value when value_vld && !frozen. The pre-toggle frozen is used, so a capture coincident with a freeze press occurs when the block was unfrozen.
- Simultaneous page and freeze events both take effect in the same cycle.
- Output: seg is registered from shadow, page and blank_lz.
  - Latency: value_vld at edge n -> shadow at n+1 -> seg at n+2.
  - Page event -> new page visible on seg one cycle after page updates.
- Nibbles above DATA_W on the last page display blank. A partial top nibble is zero-extended.
- Leading-zero blanking, computed over the whole shadow regardless of page:
  - A nibble is blank if blank_lz = 1 and it and all more-significant nibbles are zero.
  - Nibble 0 of shadow is never blanked.
- Encoding (active-low; inverted when SEG_ACTIVE_LOW=0):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - c = 0100111, d = 0100001, E = 0000110, F = 0001110
  - blank = 1111111
- Reset mid-debounce or mid-capture: all state returns to reset values. No pending event survives reset.

Test Plan:
(All scenarios use DATA_W=64, DIGITS=8, DEBOUNCE_CYC=4, SEG_ACTIVE_LOW=1.)
- Reset: assert RST mid-run with key held low -> seg all 7'h7F, page=0, frozen=0. After release with key still low, one page event occurs ~6 cycles later (2 sync + 4 debounce).
- Capture/page: value=64'h0123_4567_89AB_CDEF, vld for 1 cycle, blank_lz=0 -> 2 cycles later digit0=0001110 (F), digit7=0000000 (8). Hold key_page_n low 10 cycles -> page=1, digit0=1111000 (7), digit7=1000000 (0). Next press -> page=0 (wrap).
- Bounce: key_page_n low 3 cycles, high 1 cycle, low 3 cycles -> no page change. Then low 100 cycles -> exactly one increment.
- Freeze: freeze press, then vld with 64'hFFFF_FFFF_FFFF_FFFF -> seg unchanged, frozen=1. Second press, then vld -> all digits 0001110.
- Blanking: vld 64'hA5, blank_lz=1 -> page 0 digits 7..2 = 1111111, digit1 = 0001000, digit0 = 0010010; page 1 all blank. vld 64'h0 -> digit0 = 1000000, others blank. blank_lz=0 -> leading zeros shown as 1000000.
- Coincident: vld and freeze press in same cycle while unfrozen -> value captured, frozen=1. Page and freeze presses in same cycle -> both page and frozen update.
